// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, prefix byte constants and key event type for the PS/2 receive path
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BREAK = 8'hF0;
  typedef struct packed {
    logic [7:0] code;
    logic brk;
    logic ext;
  } key_event_t;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes one raw PS/2 line and filters glitches shorter than FILTER_LEN samples
// Ports: clk/rst_n (async active-low), raw (asynchronous line), filt (filtered level, resets high), fall (1->0 strobe of filt)
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic filt_d;
  // cnt counts consecutive synchronized samples that disagree with filt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      cnt <= '0;
      filt <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      filt_d <= filt;
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign fall = filt_d & ~filt;
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver; frames bytes, folds E0/F0 prefixes into flags and hands events over valid/ready
// Ports: clk, rst_n (async active-low), ps2_clk/ps2_data (raw lines), key_code/key_break/key_ext/key_valid/key_ready
// (event handshake), frame_err (pulse on start/parity/stop error or timeout), overrun (pulse when an event is dropped)
module ps2_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic clk_f, clk_fall, dat_f;
  frame_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic pend_ext, pend_brk, err, byte_ok, is_ext, is_brk, new_ev, accept, load;
  key_event_t hold;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (.clk(clk), .rst_n(rst_n), .raw(ps2_clk), .filt(clk_f), .fall(clk_fall));
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat (.clk(clk), .rst_n(rst_n), .raw(ps2_data), .filt(dat_f), .fall());
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    par_n = par;
    tcnt_n = (state == ST_IDLE || clk_fall) ? '0 : tcnt + TW'(1);
    err = 1'b0;
    byte_ok = 1'b0;
    if (clk_fall)
      unique case (state)
        ST_IDLE: begin
          state_n = dat_f ? ST_IDLE : ST_DATA;
          bit_cnt_n = '0;
          err = dat_f;
        end
        ST_DATA: begin
          shreg_n = {dat_f, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n = (bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_n = dat_f;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          byte_ok = dat_f & (^{shreg, par});
          err = ~byte_ok;
          state_n = ST_IDLE;
        end
      endcase
    else if (state != ST_IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
      err = 1'b1;
      state_n = ST_IDLE;
      tcnt_n = '0;
    end
  end
  assign is_ext = byte_ok && shreg == PS2_PFX_EXT;
  assign is_brk = byte_ok && shreg == PS2_PFX_BREAK;
  assign new_ev = byte_ok & ~is_ext & ~is_brk;
  assign accept = key_valid & key_ready;
  assign load = new_ev & (~key_valid | accept);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tcnt <= '0;
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
      hold <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      par <= par_n;
      tcnt <= tcnt_n;
      pend_ext <= (err | new_ev) ? 1'b0 : (is_ext | pend_ext);
      pend_brk <= (err | new_ev) ? 1'b0 : (is_brk | pend_brk);
      if (load) hold <= '{code: shreg, brk: pend_brk, ext: pend_ext};
      key_valid <= load | (key_valid & ~accept);
      frame_err <= err;
      overrun <= new_ev & ~load;
    end
  assign key_code = hold.code;
  assign key_break = hold.brk;
  assign key_ext = hold.ext;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized and directed PS/2 frames checked against a byte-level prefix/event model
module tb_ps2_rx;
  localparam int FL = 4, TO = 5000, HALF = 20;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, key_ready = 1;
  logic [7:0] key_code;
  logic key_break, key_ext, key_valid, frame_err, overrun;
  int checks = 0, failures = 0, n_err = 0, n_ovr = 0, e_err = 0;
  logic [9:0] got[$], exp_q[$];
  logic m_ext = 0, m_brk = 0;
  always #5 clk = ~clk;
  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .key_valid(key_valid), .key_ready(key_ready), .frame_err(frame_err), .overrun(overrun));
  always @(negedge clk)
    if (rst_n) begin
      if (key_valid && key_ready) got.push_back({key_code, key_break, key_ext});
      if (frame_err) n_err++;
      if (overrun) n_ovr++;
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad = 0, input int first = 0, input int last = 10);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 0;
      tick(HALF);
      ps2_clk = 1;
    end
    ps2_data = 1;
  endtask
  task automatic model(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_q.push_back({b, m_brk, m_ext});
      m_ext = 0;
      m_brk = 0;
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit bad = 0);
    send(b, bad);
    tick(40);
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
      e_err++;
    end else model(b);
  endtask
  task automatic check_events(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_errs"}, n_err, e_err);
    got.delete();
    exp_q.delete();
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_code"}, 32'(key_code), 0);
    chk({tag, "_break"}, 32'(key_break), 0);
    chk({tag, "_ext"}, 32'(key_ext), 0);
    chk({tag, "_valid"}, 32'(key_valid), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
  endtask
  initial begin
    logic [7:0] b;
    int r;
    tick(5);
    check_reset("rst0");
    rst_n = 1;
    tick(10);
    check_reset("idle");
    frame(8'h70);
    check_events("make");
    frame(8'hF0);
    frame(8'h70);
    check_events("break");
    frame(8'hE0);
    frame(8'hF0);
    frame(8'h6B);
    check_events("extbrk");
    frame(8'h69, 1);
    check_events("parity");
    frame(8'h69);
    check_events("after_par");
    frame(8'hF0);
    send(8'h55, 0, 0, 3);
    tick(TO + 10);
    tick(40);
    e_err++;
    m_ext = 0;
    m_brk = 0;
    frame(8'h72);
    check_events("timeout");
    key_ready = 0;
    frame(8'h70);
    send(8'h7A);
    tick(40);
    chk("ovr_valid", 32'(key_valid), 1);
    chk("ovr_code", 32'(key_code), 32'h70);
    chk("ovr_pulses", n_ovr, 1);
    key_ready = 1;
    tick(2);
    chk("ovr_drop_valid", 32'(key_valid), 0);
    check_events("ovr");
    ps2_clk = 0;
    tick(2);
    ps2_clk = 1;
    tick(20);
    frame(8'h1C);
    check_events("glitch");
    key_ready = 0;
    send(8'h15);
    tick(40);
    chk("pre_rst_valid", 32'(key_valid), 1);
    frame(8'hF0);
    send(8'hA5, 0, 0, 4);
    rst_n = 0;
    tick(3);
    check_reset("midrst");
    rst_n = 1;
    m_ext = 0;
    m_brk = 0;
    key_ready = 1;
    tick(5);
    send(8'hA5, 0, 5, 10);
    tick(TO + 50);
    e_err++;
    check_events("rst_partial");
    frame(8'h33);
    check_events("rst_pend");
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : b;
      frame(b, $urandom_range(0, 7) == 0);
    end
    check_events("random");
    chk("ovr_total", n_ovr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Front end of the keyboard path. It samples the raw PS/2 clock and data lines on the system clock and assembles 11-bit frames, checking start, parity and stop bits. It folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags and hands one complete key event to the instruction decoder over a valid/ready handshake. It replaces sampling on the keyboard's own clock edge, so everything downstream runs on `clk`.

## Interface
- `FILTER_LEN`, default 4: consecutive identical samples a line must hold before its filtered value changes.
- `TIMEOUT_CYCLES`, default 5000: number of `clk` cycles of no PS/2 clock falling edge mid-frame that abort the frame (100 µs at 50 MHz).
- `clk`, input, 1: system clock; the only clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ps2_clk`, input, 1: raw PS/2 clock line, asynchronous.
- `ps2_data`, input, 1: raw PS/2 data line, asynchronous.
- `key_code`, output, 8: scan code of the event (prefixes stripped).
- `key_break`, output, 1: the event was preceded by 0xF0 (key release).
- `key_ext`, output, 1: the event was preceded by 0xE0.
- `key_valid`, output, 1: an event is held and stable.
- `key_ready`, input, 1: consumer accepts the event on a cycle where `key_valid` and `key_ready` are both 1.
- `frame_err`, output, 1: one-cycle pulse on a start, parity or stop error, or on a timeout.
- `overrun`, output, 1: one-cycle pulse when a completed event is dropped.

## Operation
- Input conditioning, applied to both lines:
  - 2-flop synchronizer, then a glitch filter of `FILTER_LEN` samples.
  - A falling edge is filtered clock 1→0; the filtered data value on that cycle is the bit.
- Frame state machine:
  - IDLE: a falling edge with data 0 → DATA with bit count 0. A falling edge with data 1 → `frame_err`, stay in IDLE.
  - DATA: shift in LSB first, one bit per falling edge. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: the bit must be 1 and the 9 bits (data + parity) must have odd parity.
    - Pass → hand the byte to the prefix stage, go to IDLE.
    - Fail → `frame_err`, go to IDLE.
  - In DATA, PARITY or STOP, a gap of more than `TIMEOUT_CYCLES` with no falling edge → `frame_err`, go to IDLE.
- Prefix stage:
  - Byte 0xE0 sets a pending-ext flag; 0xF0 sets a pending-break flag; neither produces an event.
  - Any other byte produces an event {byte, pending-break, pending-ext}; both pending flags are then cleared.
  - Any `frame_err` also clears both pending flags.
- Output holding register:
  - A new event loads when the register is empty, or when it is being accepted on that same cycle.
  - If the register is full and not being accepted, the new event is dropped, the held event is kept, and `overrun` pulses.
  - `key_code`, `key_break` and `key_ext` are stable while `key_valid` = 1.

## Timing
- Reset values: `key_code` = 0x00, `key_break` = 0, `key_ext` = 0, `key_valid` = 0, `frame_err` = 0, `overrun` = 0. Frame machine in IDLE, pending flags 0.
  - Filter outputs reset to 1 (idle bus), so release of reset with lines high produces no edge.
- Latency from a raw line change to the edge being detected: 2 sync cycles + `FILTER_LEN` cycles.
- The event appears one cycle after the stop-bit edge is detected:
  - `key_valid` rises on that cycle.
  - `frame_err` and `overrun` pulse on the same cycle the error or drop is detected.
- `key_valid` falls on the cycle after acceptance, unless a new event loads on that same cycle, in which case it stays 1.
- Asserting `rst_n` mid-frame clears the frame immediately and the partial frame is discarded.
  - After release, a partial frame still on the wire produces a frame error (bad start or timeout), never an event.
- The timeout counter restarts on every detected falling edge and is held at 0 in IDLE.

## Structure
- Shared package `ps2_pkg` holds:
  - the frame state enum (IDLE, DATA, PARITY, STOP);
  - the constants `PS2_PFX_EXT` = 8'hE0 and `PS2_PFX_BREAK` = 8'hF0;
  - the event struct {code, brk, ext}.
- One sub-module, `ps2_line_filter` (synchronizer + glitch filter, parameter `FILTER_LEN`), instantiated twice.
  - It also outputs a `fall` strobe, which is used only from the clock-line instance.
- Frame machine, timeout counter, prefix stage and holding register live in `ps2_rx`.

## Test plan
- Make code: frame 0x70 with correct parity, `key_ready` = 1 → one `key_valid` cycle, `key_code` = 0x70, break 0, ext 0.
- Break and extended prefixes: frames F0,70 → single event 0x70 with break 1. Frames E0,F0,6B → single event 0x6B with break 1, ext 1.
- Parity error: frame 0x69 with even parity → `frame_err` pulse, no event. A following good 0x69 → event with break 0, ext 0.
- Timeout and prefix clearing: F0, then stop toggling `ps2_clk` after 4 bits of the next frame for `TIMEOUT_CYCLES` + 10 → `frame_err`. The next frame 0x72 → event 0x72 with break 0 (pending flag cleared).
- Overrun: `key_ready` = 0, send 0x70 then 0x7A → `key_code` stays 0x70 and `overrun` pulses once. Then `key_ready` = 1 → 0x70 accepted and `key_valid` drops.
- Glitch and reset: a 2-cycle low glitch on `ps2_clk` → no bit captured. Assert `rst_n` low after 5 bits of a frame → all outputs at reset values, and no event after release.
